// File: rtl/framebuffer_xor.sv
// framebuffer_xor: dual-use framebuffer with a free-running display read port and a READ/WRITE/XOR/CLEAR command port
module framebuffer_xor #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_out,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              collision
);
  typedef enum logic [1:0] {IDLE, RD, XWR, CLR} state_t;
  localparam logic [ADDR_W:0]   DEP  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] PEN  = ADDR_W'(DEPTH-2);
  state_t state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_cnt, x_addr, wa;
  logic [DATA_W-1:0] x_data, old, xr, wd;
  logic x_ok, acc, in_rng, we, clr_done;
  assign cmd_ready = state == IDLE && !reset;
  assign acc       = cmd_valid && cmd_ready;
  assign in_rng    = {1'b0, cmd_addr} < DEP;
  assign old       = in_rng ? mem[cmd_addr] : '0;
  assign xr        = old ^ cmd_data;
  assign clr_done  = state == CLR && clr_cnt == PEN;
  always_comb begin
    state_n = state;
    if (state == IDLE && acc)
      state_n = cmd_op == 2'b00 ? RD : cmd_op == 2'b10 ? XWR : cmd_op == 2'b11 ? CLR : IDLE;
    else if (state == RD || state == XWR)
      state_n = IDLE;
    else if (state == CLR)
      state_n = clr_cnt == LAST ? IDLE : CLR;
    we = (acc && cmd_op == 2'b01 && in_rng) || (state == XWR && x_ok) || state == CLR;
    wa = state == XWR ? x_addr : state == CLR ? clr_cnt : cmd_addr;
    wd = state == XWR ? x_data : state == CLR ? '0 : cmd_data;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // Responses are registered at accept so READ/WRITE/XOR all answer one cycle later
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      collision <= 1'b0;
      disp_out  <= '0;
      x_addr    <= '0;
      x_data    <= '0;
      x_ok      <= 1'b0;
    end else begin
      state     <= state_n;
      disp_out  <= {1'b0, disp_addr} < DEP ? mem[disp_addr] : '0;
      clr_cnt   <= state == CLR && clr_cnt != LAST ? clr_cnt + 1'b1 : '0;
      rsp_valid <= (acc && cmd_op != 2'b11) || clr_done;
      if (acc && cmd_op != 2'b11) begin
        rsp_data  <= !in_rng ? '0 : cmd_op == 2'b10 ? xr : cmd_op == 2'b01 ? cmd_data : old;
        collision <= in_rng && cmd_op == 2'b10 && |(old & cmd_data);
      end else if (clr_done) begin
        rsp_data  <= '0;
        collision <= 1'b0;
      end
      if (acc) begin
        x_addr <= cmd_addr;
        x_data <= xr;
        x_ok   <= in_rng;
      end
    end
endmodule

// File: tb/tb_framebuffer_xor.sv
// tb_framebuffer_xor: table, directed and random checks of framebuffer_xor against an array model
module tb_framebuffer_xor;
  localparam logic [1:0] OP_R = 2'd0, OP_W = 2'd1, OP_X = 2'd2, OP_C = 2'd3;
  logic clk = 0, reset = 1;
  logic [8:0] disp_addr = 0, cmd_addr = 0;
  logic [15:0] disp_out, cmd_data = 0, rsp_data;
  logic cmd_valid = 0, cmd_ready, rsp_valid, collision;
  logic [1:0] cmd_op = 0;
  logic [8:0] c3_disp_addr = 0, c3_addr = 0;
  logic [15:0] c3_disp_out, c3_data = 0, c3_rsp_data;
  logic c3_valid = 0, c3_ready, c3_rsp_valid, c3_col;
  logic [1:0] c3_op = 0;
  logic [15:0] ref_mem [512];
  int vectors = 0, miscompares = 0;
  typedef struct { logic [1:0] op; logic [8:0] a; logic [15:0] d; logic [15:0] er; logic ec; } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  framebuffer_xor dut (
    .clk(clk), .reset(reset), .disp_addr(disp_addr), .disp_out(disp_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .collision(collision));

  framebuffer_xor #(.DATA_W(16), .DEPTH(300), .ADDR_W(9)) dut3 (
    .clk(clk), .reset(reset), .disp_addr(c3_disp_addr), .disp_out(c3_disp_out),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op), .cmd_addr(c3_addr),
    .cmd_data(c3_data), .rsp_valid(c3_rsp_valid), .rsp_data(c3_rsp_data), .collision(c3_col));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [8:0] a, input logic [15:0] d,
                        output logic [15:0] r, output logic c);
    logic [15:0] er;
    logic ec;
    int lat, n;
    lat = op == OP_C ? 512 : 1;
    er = 0;
    ec = 0;
    case (op)
      OP_R: er = ref_mem[a];
      OP_W: begin er = d; ref_mem[a] = d; end
      OP_X: begin er = ref_mem[a] ^ d; ec = |(ref_mem[a] & d); ref_mem[a] = er; end
      default: for (int i = 0; i < 512; i++) ref_mem[i] = 0;
    endcase
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = 9'($urandom); cmd_data = 16'($urandom);
    n = 1;
    while (!rsp_valid && n < lat + 8) begin @(negedge clk); n++; end
    chk("rsp_latency", n, lat);
    chk("rsp_data", 32'(rsp_data), 32'(er));
    chk("collision", 32'(collision), 32'(ec));
    r = rsp_data;
    c = collision;
    @(negedge clk);
    chk("rsp_once", 32'(rsp_valid), 0);
    chk("rsp_hold", 32'(rsp_data), 32'(er));
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      disp_addr = 9'(a);
      @(negedge clk);
      chk("disp_out", 32'(disp_out), 32'(ref_mem[a]));
    end
  endtask

  task automatic c3_cmd(input logic [1:0] op, input logic [8:0] a, input logic [15:0] d,
                        input int lat, input logic [15:0] er, input logic rdy);
    int n;
    n = 0;
    while (!c3_ready && n < 2000) begin @(negedge clk); n++; end
    chk("c3_ready", 32'(c3_ready), 1);
    c3_valid = 1; c3_op = op; c3_addr = a; c3_data = d;
    @(negedge clk);
    c3_valid = 0; c3_addr = 9'($urandom); c3_data = 16'($urandom);
    n = 1;
    while (!c3_rsp_valid && n < lat + 8) begin @(negedge clk); n++; end
    chk("c3_latency", n, lat);
    chk("c3_rsp_data", 32'(c3_rsp_data), 32'(er));
    chk("c3_collision", 32'(c3_col), 0);
    chk("c3_ready_at_rsp", 32'(c3_ready), 32'(rdy));
    @(negedge clk);
    chk("c3_idle_after", 32'(c3_ready), 1);
    chk("c3_rsp_once", 32'(c3_rsp_valid), 0);
  endtask

  initial begin
    logic [15:0] r;
    logic c;
    tbl[0] = '{OP_W, 9'd5, 16'h00F0, 16'h00F0, 1'b0};
    tbl[1] = '{OP_X, 9'd5, 16'h0F18, 16'h0FE8, 1'b1};
    tbl[2] = '{OP_X, 9'd5, 16'h0FE8, 16'h0000, 1'b1};
    tbl[3] = '{OP_X, 9'd5, 16'h0001, 16'h0001, 1'b0};
    tbl[4] = '{OP_R, 9'd5, 16'hFFFF, 16'h0001, 1'b0};
    tbl[5] = '{OP_W, 9'd511, 16'h1234, 16'h1234, 1'b0};
    tbl[6] = '{OP_X, 9'd511, 16'hFFFF, 16'hEDCB, 1'b1};
    tbl[7] = '{OP_R, 9'd511, 16'h0000, 16'hEDCB, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_collision", 32'(collision), 0);
    chk("reset_disp_out", 32'(disp_out), 0);
    reset = 0;
    #1 chk("ready_after_reset", 32'(cmd_ready), 1);
    chk("c3_ready_after_reset", 32'(c3_ready), 1);
    @(negedge clk);
    do_cmd(OP_C, 9'd0, 16'h0, r, c);
    sweep(0, 511);
    for (int i = 0; i < 8; i++) begin
      do_cmd(tbl[i].op, tbl[i].a, tbl[i].d, r, c);
      chk($sformatf("tbl%0d_data", i), 32'(r), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_col", i), 32'(c), 32'(tbl[i].ec));
    end
    cmd_valid = 1; cmd_op = OP_W; cmd_addr = 0; cmd_data = 16'hA000;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ref_mem[i-1] = 16'hA000 + 16'(i-1);
      chk("b2b_ready", 32'(cmd_ready), 1);
      chk("b2b_rsp_valid", 32'(rsp_valid), 1);
      chk("b2b_rsp_data", 32'(rsp_data), 32'(16'hA000 + 16'(i-1)));
      if (i < 4) begin cmd_addr = 9'(i); cmd_data = 16'hA000 + 16'(i); end
      else cmd_valid = 0;
    end
    @(negedge clk);
    chk("b2b_rsp_end", 32'(rsp_valid), 0);
    for (int i = 0; i < 4; i++) do_cmd(OP_R, 9'(i), 16'h0, r, c);
    do_cmd(OP_W, 9'd7, 16'h5555, r, c);
    disp_addr = 7; cmd_valid = 1; cmd_op = OP_W; cmd_addr = 7; cmd_data = 16'hAAAA;
    @(negedge clk);
    cmd_valid = 0;
    chk("disp_old", 32'(disp_out), 32'h5555);
    chk("disp_wr_rsp", 32'(rsp_data), 32'hAAAA);
    @(negedge clk);
    chk("disp_new", 32'(disp_out), 32'hAAAA);
    ref_mem[7] = 16'hAAAA;
    for (int i = 0; i < 300; i++)
      do_cmd(2'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15)),
             16'($urandom), r, c);
    sweep(0, 31);
    for (int a = 90; a < 110; a++) do_cmd(OP_W, 9'(a), 16'h8000 | 16'(a), r, c);
    cmd_valid = 1; cmd_op = OP_C;
    @(negedge clk);
    cmd_valid = 0;
    repeat (99) begin
      chk("abort_no_rsp", 32'(rsp_valid), 0);
      @(negedge clk);
    end
    reset = 1;
    #1;
    chk("abort_ready", 32'(cmd_ready), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_rsp_data", 32'(rsp_data), 0);
    chk("abort_collision", 32'(collision), 0);
    chk("abort_disp_out", 32'(disp_out), 0);
    for (int i = 0; i < 99; i++) ref_mem[i] = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1 chk("abort_ready_release", 32'(cmd_ready), 1);
    repeat (20) begin
      @(negedge clk);
      chk("abort_quiet", 32'(rsp_valid), 0);
    end
    sweep(0, 109);
    c3_cmd(OP_C, 9'd0, 16'h0, 300, 16'h0, 1'b0);
    c3_cmd(OP_W, 9'd299, 16'hBEEF, 1, 16'hBEEF, 1'b1);
    c3_cmd(OP_W, 9'd0, 16'h1111, 1, 16'h1111, 1'b1);
    c3_cmd(OP_W, 9'd310, 16'h7777, 1, 16'h0, 1'b1);
    c3_cmd(OP_R, 9'd310, 16'h0, 1, 16'h0, 1'b0);
    c3_cmd(OP_X, 9'd305, 16'hFFFF, 1, 16'h0, 1'b0);
    c3_cmd(OP_R, 9'd299, 16'h0, 1, 16'hBEEF, 1'b0);
    for (int a = 0; a < 320; a++) begin
      c3_disp_addr = 9'(a);
      @(negedge clk);
      chk("c3_disp", 32'(c3_disp_out), a == 0 ? 32'h1111 : a == 299 ? 32'hBEEF : 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/framebuffer_xor.md
FRAMEBUFFER_XOR -- requirements
Module: framebuffer_xor

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512: number of words; any value >= 2, not necessarily a power of two.
REQ-003 SHALL have parameter ADDR_W, default 9: address width, >= clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port disp_addr, input, ADDR_W: display read address.
REQ-007 SHALL have port disp_out, output, DATA_W: registered display read data.
REQ-008 SHALL have port cmd_valid, input, 1: command request.
REQ-009 SHALL have port cmd_ready, output, 1: command accept.
REQ-010 SHALL have port cmd_op, input, 2: 00 READ, 01 WRITE, 10 XOR, 11 CLEAR.
REQ-011 SHALL have port cmd_addr, input, ADDR_W: command address.
REQ-012 SHALL have port cmd_data, input, DATA_W: command data.
REQ-013 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port rsp_data, output, DATA_W: result word.
REQ-015 SHALL have port collision, output, 1: XOR collision flag.

Function
REQ-016 SHALL store DEPTH x DATA_W words; storage is not reset and is undefined until written or cleared.
REQ-017 SHALL load disp_out with mem[disp_addr] every cycle, 1-cycle latency; a same-cycle write to that address returns old data; disp_addr >= DEPTH returns 0.
REQ-018 SHALL accept a command in a cycle where cmd_valid and cmd_ready are both 1; cmd_valid with cmd_ready low is ignored, and the requester holds it.
REQ-019 SHALL implement FSM states IDLE, RD, XWR, CLR; cmd_ready = 1 only in IDLE.
REQ-020 READ accepted in cycle N: state RD in N+1, with rsp_valid=1 and rsp_data=mem[cmd_addr]; IDLE in N+2.
REQ-021 WRITE accepted in cycle N: writes cmd_data at the end of N; rsp_valid=1, rsp_data=cmd_data, collision=0 in N+1; state stays IDLE, so back-to-back WRITEs run at one per cycle.
REQ-022 XOR accepted in cycle N: reads old word in N; in N+1 (XWR) writes old^cmd_data, and asserts rsp_valid=1, rsp_data=old^cmd_data, collision=|(old & cmd_data); IDLE in N+2.
REQ-023 XOR SHALL register cmd_data/cmd_addr at accept; input changes after accept have no effect.
REQ-024 CLEAR accepted in cycle N: writes 0 to address k in cycle N+1+k for k = 0..DEPTH-1; rsp_valid=1, rsp_data=0, collision=0 in cycle N+DEPTH; IDLE in N+DEPTH+1; cmd_addr/cmd_data ignored.
REQ-025 The CLEAR counter SHALL terminate at DEPTH-1 without wrapping, for both power-of-two and non-power-of-two DEPTH.
REQ-026 READ/WRITE/XOR with cmd_addr >= DEPTH SHALL suppress the write, return rsp_data=0 and collision=0, and keep normal timing.
REQ-027 rsp_data and collision SHALL hold their values until the next rsp_valid pulse.
REQ-028 Display reads SHALL never stall or be stalled by commands, including during CLEAR.

Reset
REQ-029 While reset=1: state IDLE, CLEAR counter 0, cmd_ready=0, rsp_valid=0, rsp_data=0, collision=0, disp_out=0.
REQ-030 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset mid-CLEAR or mid-XOR SHALL abort with no further writes and no rsp_valid; already-cleared words stay 0.

Verification
REQ-032 CLEAR on DEPTH=512, then sweep disp_addr 0..511 -> all disp_out 0; rsp_valid exactly once, 512 cycles after accept.
REQ-033 WRITE addr 5 = 0x00F0, then XOR addr 5 with 0x0F18 -> rsp_data 0x0FE8, collision 1; XOR 0x0FE8 again -> rsp_data 0x0000, collision 1; XOR 0x0001 -> 0x0001, collision 0.
REQ-034 WRITEs to addrs 0..3 on consecutive cycles -> cmd_ready stays 1, four rsp_valid pulses, READ-back matches.
REQ-035 DEPTH=300, CLEAR -> last write at addr 299, no write at 300+, rsp_valid at N+300; WRITE addr 310 -> memory unchanged, rsp_data 0.
REQ-036 Reset asserted at cycle N+100 of a CLEAR -> no rsp_valid; addrs 0..98 read 0; cmd_ready=1 the first cycle after reset release.
REQ-037 disp_addr=7 held while WRITE addr 7 = 0xAAAA -> disp_out shows old value next cycle and 0xAAAA the cycle after.
